// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: arbitrates cpu (MEM stage) and loader/DMA ports onto a fixed-latency memory.
// Define DMEM_CTRL_PERF_EN to add the perf_stall_cycles / perf_dma_xfers counters.
module dmem_access_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_dma_xfers
`endif
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_INIT   = CW'(LATENCY - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_accept;
  logic              w_dma_win;
  logic              w_we_sel;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [DATA_W-1:0] w_wdata_sel;

  logic [CW-1:0]     r_cnt;
  logic [SW-1:0]     r_starve;
  logic              r_owner_dma;
  logic              r_we;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_cpu_done;
  logic              r_dma_done;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_dma_win    = dma_req & (~cpu_req | (r_starve == STARVE_MAX));
    case (r_state)
      S_IDLE: begin
        if (cpu_req | dma_req) begin
          w_accept     = 1'b1;
          w_next_state = S_BUSY;
        end
      end
      S_BUSY:  if (r_cnt == '0) w_next_state = S_RESP;
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_we_sel    = w_dma_win ? dma_we    : cpu_we;
  assign w_addr_sel  = w_dma_win ? dma_addr  : cpu_addr;
  assign w_wdata_sel = w_dma_win ? dma_wdata : cpu_wdata;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_owner_dma <= 1'b0;
      r_we        <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_done  <= 1'b0;
      r_dma_done  <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_cpu_done <= 1'b0;
      r_dma_done <= 1'b0;
      if (w_accept) begin
        r_owner_dma <= w_dma_win;
        r_we        <= w_we_sel;
        r_mem_addr  <= w_addr_sel;
        r_mem_wdata <= w_wdata_sel;
        r_mem_read  <= ~w_we_sel;
        r_mem_write <= w_we_sel;
        r_cnt       <= CNT_INIT;
      end else if (r_state == S_BUSY) begin
        if (r_cnt == '0) begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_cpu_done  <= ~r_owner_dma;
          r_dma_done  <= r_owner_dma;
          if (!r_we && r_owner_dma)  r_dma_rdata <= mem_rdata;
          if (!r_we && !r_owner_dma) r_cpu_rdata <= mem_rdata;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  // Starvation counter: only counts cpu wins that actually made a waiting dma lose.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                   r_starve <= '0;
    else if (!dma_req)                            r_starve <= '0;
    else if (w_accept && w_dma_win)               r_starve <= '0;
    else if (w_accept && r_starve != STARVE_MAX)  r_starve <= r_starve + 1'b1;
  end

  assign cpu_stall = cpu_req & ~r_cpu_done;
  assign cpu_done  = r_cpu_done;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_gnt   = w_accept & w_dma_win;
  assign dma_done  = r_dma_done;
  assign dma_rdata = r_dma_rdata;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

`ifdef DMEM_CTRL_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_dma;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_stall <= '0;
      r_perf_dma   <= '0;
    end else begin
      if (cpu_stall && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 1'b1;
      if (r_dma_done && r_perf_dma != '1)  r_perf_dma   <= r_perf_dma + 1'b1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_dma_xfers    = r_perf_dma;
`endif

endmodule
